adder_mult_seq: RTL and testbench
=================================

Name: adder_mult_seq

Overview:
- Sequential shift-add multiplier controller that time-shares one external 11-bit ripple full adder (A/B/Cin to Sum/Cout).
- Latches an unsigned multiplicand and multiplier on a start handshake.
- Drives the adder once per multiplier bit, accumulating partial products in an internal register.
- Presents the product with a one-cycle done pulse; used wherever the datapath needs multiplication without a dedicated array multiplier.

Parameters:
- ADD_W, 11, width of the shared adder and of the product/accumulator.
- W_M, 5, multiplicand width.
- W_Q, 6, multiplier width; equals the number of RUN cycles. Constraint: W_M + W_Q <= ADD_W (elaboration-time check, fatal if violated).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- mcand  input  W_M  multiplicand, captured with start.
- mplier  input  W_Q  multiplier, captured with start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse, product valid.
- product  output  ADD_W  registered result, held until next accepted start.
- ovf  output  1  sticky: any adder carry-out seen in the last operation.
- add_a  output  ADD_W  to adder A.
- add_b  output  ADD_W  to adder B.
- add_cin  output  1  to adder Cin; tied 0.
- add_sum  input  ADD_W  from adder Sum.
- add_cout  input  1  from adder Cout.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); no asynchronous logic.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0, ovf=0, acc=0, cnt=0, internal operand registers=0.
- Reset asserted mid-operation: next edge returns to IDLE with all reset values; the in-flight result is discarded and no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1: capture mcand zero-extended to ADD_W into m_reg, capture mplier into q_reg, acc<=0, cnt<=0, ovf<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (exactly W_Q cycles):
  - Combinational drive: add_a=acc; add_b=(q_reg[cnt] ? m_reg<<cnt : 0), truncated to ADD_W; add_cin=0.
  - Each edge: acc<=add_sum; ovf<=ovf | add_cout; cnt<=cnt+1.
  - When cnt==W_Q-1, the edge goes to DONE and also loads product<=add_sum.
  - Zero multiplier bits still consume a cycle (add 0), giving fixed latency.
- DONE (one cycle):
  - done=1, busy=1, ready=0; go to IDLE unconditionally.
  - start during DONE is ignored.
- Outside RUN: add_a=0, add_b=0, add_cin=0, so the shared adder sees a quiescent input.
- Latency: start sampled at edge t; RUN occupies cycles t+1..t+W_Q; done=1 in cycle t+W_Q+1; ready=1 again at t+W_Q+2. Defaults give 8 cycles start-to-ready.
- start while busy: ignored, with no effect on operands or state.
- A start held high continuously: a new operation is accepted on the first IDLE cycle after DONE (back-to-back throughput 1 op per W_Q+2 cycles).
- Width rule: arithmetic is unsigned modulo 2^ADD_W. With the parameter constraint, ovf must remain 0 for any operands; it exists as a checker against a faulty adder.
- product changes only on the RUN-to-DONE edge and on reset.
- cnt width: clog2(W_Q) bits; no wrap is reachable inside RUN.

Test Plan:
- Reset, then idle 5 cycles -> ready=1, busy=0, done=0, product=0, ovf=0, add_a=add_b=0 throughout.
- start with mcand=31, mplier=63 -> exactly 6 RUN cycles; done pulses one cycle at start+7; product=1953; ovf=0; ready back at start+8.
- start with mcand=0, mplier=45, then mcand=13, mplier=0 -> both give product=0 with identical latency. The add_b sequence for 13*5 (mplier=5) is 13, 0, 52, 0, 0, 0, with product=65.
- start pulsed again during RUN with mcand=1, mplier=1 while computing 7*9 -> request ignored; product=63; next op completes only after a fresh start in IDLE.
- start held high with operands 3*4 then 5*6 -> two done pulses 8 cycles apart; product=12, then 30.
- rst asserted on the third RUN cycle of 20*50 -> next cycle IDLE, product=0, no done pulse. A following 2*3 yields product=6 and ovf=0. A forced add_cout=1 injection during RUN sets ovf=1 and holds it until the next accepted start.

Source files
------------

// File: rtl/adder_mult_seq.sv
// adder_mult_seq: shift-add multiplier sharing one external ADD_W adder.
// Ports: clk/rst, start/mcand/mplier in, ready/busy/done/product/ovf out,
//   add_a/add_b/add_cin to the adder, add_sum/add_cout from the adder.
module adder_mult_seq #(
  parameter int ADD_W = 11,
  parameter int W_M   = 5,
  parameter int W_Q   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_M-1:0]   mcand,
  input  logic [W_Q-1:0]   mplier,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [ADD_W-1:0] product,
  output logic             ovf,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_cin,
  input  logic [ADD_W-1:0] add_sum,
  input  logic             add_cout
);

  localparam int CW = (W_Q > 1) ? $clog2(W_Q) : 1;

  if (W_M + W_Q > ADD_W) begin : g_width_chk
    $fatal(1, "adder_mult_seq: W_M + W_Q exceeds ADD_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ADD_W-1:0] m_reg;
  logic [W_Q-1:0]   q_reg;
  logic [ADD_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

  assign last   = (cnt == CW'(W_Q - 1));
  assign accept = (state == IDLE) && start;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        add_a = acc;
        // zero multiplier bits still add 0 so latency is fixed
        if (q_reg[cnt]) add_b = m_reg << cnt;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_reg   <= '0;
      q_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        m_reg <= ADD_W'(mcand);
        q_reg <= mplier;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (state == RUN) begin
        acc <= add_sum;
        // carry-out can only appear with a faulty adder
        ovf <= ovf | add_cout;
        cnt <= cnt + CW'(1);
        if (last) product <= add_sum;
      end
    end
  end

endmodule

// File: tb/tb_adder_mult_seq.sv
// tb_adder_mult_seq: directed self-checking bench for adder_mult_seq.
// Models the shared adder and injects a faulty carry-out on demand.
module tb_adder_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  mcand;
  logic [5:0]  mplier;
  logic        ready;
  logic        busy;
  logic        done;
  logic [10:0] product;
  logic        ovf;
  logic [10:0] add_a;
  logic [10:0] add_b;
  logic        add_cin;
  logic [10:0] add_sum;
  logic        add_cout;
  logic        inj_cout;
  logic [11:0] s12;

  int checks = 0;
  int errors = 0;
  logic [10:0] ea [6];
  logic [10:0] eb [6];

  always #5 clk = ~clk;

  assign s12      = {1'b0, add_a} + {1'b0, add_b} + {11'b0, add_cin};
  assign add_sum  = s12[10:0];
  assign add_cout = s12[11] | inj_cout;

  adder_mult_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .ovf      (ovf),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rdy_wait", {31'b0, ready}, 1);
  endtask

  task automatic op(input logic [4:0] mc, input logic [5:0] mq,
                    input logic [10:0] ep, input logic eo,
                    input int poke, input int injc, input logic useab);
    wait_ready();
    mcand  = mc;
    mplier = mq;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("run_busy", {31'b0, busy}, 1);
      chk("run_rdy", {31'b0, ready}, 0);
      chk("run_done", {31'b0, done}, 0);
      chk("run_cin", {31'b0, add_cin}, 0);
      if (i == 0) chk("ovf_clr", {31'b0, ovf}, 0);
      if (useab) begin
        chk("add_a", {21'b0, add_a}, {21'b0, ea[i]});
        chk("add_b", {21'b0, add_b}, {21'b0, eb[i]});
      end
      if (i == poke) begin
        start  = 1'b1;
        mcand  = 5'd1;
        mplier = 6'd1;
      end else begin
        start = 1'b0;
      end
      inj_cout = (i == injc);
      tick();
    end
    inj_cout = 1'b0;
    start    = 1'b0;
    chk("dn_done", {31'b0, done}, 1);
    chk("dn_busy", {31'b0, busy}, 1);
    chk("dn_rdy", {31'b0, ready}, 0);
    chk("dn_prod", {21'b0, product}, {21'b0, ep});
    chk("dn_ovf", {31'b0, ovf}, {31'b0, eo});
    chk("dn_adda", {21'b0, add_a}, 0);
    chk("dn_addb", {21'b0, add_b}, 0);
    tick();
    chk("post_rdy", {31'b0, ready}, 1);
    chk("post_done", {31'b0, done}, 0);
    chk("post_prod", {21'b0, product}, {21'b0, ep});
    chk("post_ovf", {31'b0, ovf}, {31'b0, eo});
  endtask

  initial begin
    int nd;
    int d1;
    rst      = 1'b1;
    start    = 1'b0;
    mcand    = '0;
    mplier   = '0;
    inj_cout = 1'b0;
    nd       = 0;
    d1       = 0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      chk("rst_rdy", {31'b0, ready}, 1);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_prod", {21'b0, product}, 0);
      chk("rst_ovf", {31'b0, ovf}, 0);
      chk("rst_adda", {21'b0, add_a}, 0);
      chk("rst_addb", {21'b0, add_b}, 0);
      tick();
    end

    op(5'd31, 6'd63, 11'd1953, 1'b0, -1, -1, 1'b0);
    op(5'd0, 6'd45, 11'd0, 1'b0, -1, -1, 1'b0);
    op(5'd13, 6'd0, 11'd0, 1'b0, -1, -1, 1'b0);

    eb[0] = 11'd13; eb[1] = 11'd0; eb[2] = 11'd52;
    eb[3] = 11'd0;  eb[4] = 11'd0; eb[5] = 11'd0;
    ea[0] = 11'd0;  ea[1] = 11'd13; ea[2] = 11'd13;
    ea[3] = 11'd65; ea[4] = 11'd65; ea[5] = 11'd65;
    op(5'd13, 6'd5, 11'd65, 1'b0, -1, -1, 1'b1);

    op(5'd7, 6'd9, 11'd63, 1'b0, 2, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("poke_idle", {31'b0, ready}, 1);
      chk("poke_busy", {31'b0, busy}, 0);
      tick();
    end

    wait_ready();
    mcand  = 5'd3;
    mplier = 6'd4;
    start  = 1'b1;
    tick();
    mcand  = 5'd5;
    mplier = 6'd6;
    for (int c = 1; c <= 24 && nd < 2; c++) begin
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("held_p1", {21'b0, product}, 12);
          d1 = c;
        end else begin
          chk("held_p2", {21'b0, product}, 30);
          chk("held_gap", c - d1, 8);
          start = 1'b0;
        end
      end
      tick();
    end
    start = 1'b0;
    chk("held_cnt", nd, 2);

    wait_ready();
    mcand  = 5'd20;
    mplier = 6'd50;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_busy", {31'b0, busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_rdy", {31'b0, ready}, 1);
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_done", {31'b0, done}, 0);
    chk("mrst_prod", {21'b0, product}, 0);
    chk("mrst_ovf", {31'b0, ovf}, 0);
    for (int i = 0; i < 8; i++) begin
      chk("mrst_nodone", {31'b0, done}, 0);
      tick();
    end

    op(5'd2, 6'd3, 11'd6, 1'b0, -1, -1, 1'b0);
    op(5'd2, 6'd3, 11'd6, 1'b1, -1, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_hold", {31'b0, ovf}, 1);
      tick();
    end
    op(5'd1, 6'd1, 11'd1, 1'b0, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
